// File: rtl/mem_bridge.sv
// mem_bridge: bridge between the CPU global memory port and a single-port
// synchronous 32-bit word RAM. It takes one-shot read/write requests and
// performs word, halfword and byte accesses. Sub-word stores use
// read-modify-write. Load data is extended and returned on dataIn, with a
// one-cycle ready pulse.
//
// Parameters:
//   ADDR_W  RAM word-address width
//   RD_LAT  RAM read latency (1..4), from the ram_en cycle to valid ram_rdata
// Ports:
//   clk, rst (async, active-low)
//   Gmem_R/Gmem_W, GmemAddr, dataOut, MEM_C, MEM_S  - CPU request
//   dataIn, ready, err                              - CPU response
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata  - RAM port
// Optional feature: define MEM_BRIDGE_ALIGN_CHECK_EN to reject misaligned
// word/halfword accesses with an err pulse and no RAM access.
module mem_bridge #(
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Gmem_R,
    input  logic              Gmem_W,
    input  logic [31:0]       GmemAddr,
    input  logic [31:0]       dataOut,
    input  logic [1:0]        MEM_C,
    input  logic              MEM_S,
    output logic [31:0]       dataIn,
    output logic              ready,
    output logic              err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_LAT);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              is_wr, is_wr_d;
    logic [1:0]        size_q, size_d;   // 00 word, 01 half, 10 byte
    logic              sgn_q, sgn_d;
    logic [1:0]        lane_q, lane_d;   // byte offset of the target lane
    logic [31:0]       sdata_q, sdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d, din_d;
    logic              rdy_d, en_d, we_d;
    logic              req, mis;
    logic [1:0]        req_size;

    // Address bits above the RAM range are ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^GmemAddr[31:ADDR_W+2];

    assign req      = Gmem_R | Gmem_W;
    assign req_size = (MEM_C == 2'b11) ? 2'b00 : MEM_C;

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    assign mis = ((req_size == 2'b00) && (GmemAddr[1:0] != 2'b00)) ||
                 ((req_size == 2'b01) && GmemAddr[0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else      err <= (state == IDLE) && req && mis;
    end
`else
    assign mis = 1'b0;
    assign err = 1'b0;
`endif

    // Pick the target lane out of the RAM word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] ln, input logic sg);
        logic [31:0] sh;
        sh = w >> {ln, 3'b000};
        case (sz)
            2'b01:   extract = {{16{sg & sh[15]}}, sh[15:0]};
            2'b10:   extract = {{24{sg & sh[7]}}, sh[7:0]};
            default: extract = w;
        endcase
    endfunction

    // Replace only the target lane of the RAM word with the store data.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] ln);
        logic [31:0] m;
        m = ((sz == 2'b01) ? 32'h0000_FFFF : 32'h0000_00FF) << {ln, 3'b000};
        merge = (w & ~m) | ((d << {ln, 3'b000}) & m);
    endfunction

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        is_wr_d = is_wr;
        size_d  = size_q;
        sgn_d   = sgn_q;
        lane_d  = lane_q;
        sdata_d = sdata_q;
        addr_d  = ram_addr;
        wdata_d = ram_wdata;
        din_d   = dataIn;
        rdy_d   = 1'b0;
        en_d    = 1'b0;
        we_d    = 1'b0;
        case (state)
            IDLE: if (req) begin
                is_wr_d = Gmem_W;            // write wins when both are high
                size_d  = req_size;
                sgn_d   = MEM_S;
                sdata_d = dataOut;
                // Misaligned low bits are dropped so word/half lanes stay aligned.
                case (req_size)
                    2'b01:   lane_d = {GmemAddr[1], 1'b0};
                    2'b10:   lane_d = GmemAddr[1:0];
                    default: lane_d = 2'b00;
                endcase
                if (mis) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                end else if (Gmem_W && (req_size == 2'b00)) begin
                    state_d = WR;
                    addr_d  = GmemAddr[ADDR_W+1:2];
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = dataOut;
                end else begin
                    // Loads and sub-word stores both start with a RAM read.
                    state_d = RD_WAIT;
                    cnt_d   = '0;
                    addr_d  = GmemAddr[ADDR_W+1:2];
                    en_d    = 1'b1;
                end
            end
            RD_WAIT: begin
                if (cnt == CNT_MAX) begin
                    if (is_wr) begin
                        state_d = WR;
                        en_d    = 1'b1;
                        we_d    = 1'b1;
                        wdata_d = merge(ram_rdata, sdata_q, size_q, lane_q);
                    end else begin
                        state_d = DONE;
                        rdy_d   = 1'b1;
                        din_d   = extract(ram_rdata, size_q, lane_q, sgn_q);
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WR: begin
                state_d = DONE;
                rdy_d   = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_wr     <= 1'b0;
            size_q    <= 2'b00;
            sgn_q     <= 1'b0;
            lane_q    <= 2'b00;
            sdata_q   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            dataIn    <= '0;
            ready     <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            is_wr     <= is_wr_d;
            size_q    <= size_d;
            sgn_q     <= sgn_d;
            lane_q    <= lane_d;
            sdata_q   <= sdata_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            dataIn    <= din_d;
            ready     <= rdy_d;
            ram_en    <= en_d;
            ram_we    <= we_d;
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: two instances (RD_LAT=1 and RD_LAT=3) share the CPU
// request, each with its own RAM model. A reference memory predicts load
// data, merged store words, per-cycle ram_en/ram_we/ready patterns and the
// completion latency; expected responses go through per-instance queues.
module tb_mem_bridge;

    localparam int AW = 11;

    typedef struct {
        logic [31:0] data;
        int          lat;
        logic        err;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        gr, gw, ms;
    logic [31:0] ga, gd;
    logic [1:0]  mc;

    logic [31:0]   din1, din3, wd1, wd3, rdata1, rdata3;
    logic          rdy1, rdy3, err1, err3, en1, en3, we1, we3;
    logic [AW-1:0] ad1, ad3;

    mem_bridge #(.ADDR_W(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst_n), .Gmem_R(gr), .Gmem_W(gw), .GmemAddr(ga), .dataOut(gd),
        .MEM_C(mc), .MEM_S(ms), .dataIn(din1), .ready(rdy1), .err(err1), .ram_en(en1),
        .ram_we(we1), .ram_addr(ad1), .ram_wdata(wd1), .ram_rdata(rdata1));

    mem_bridge #(.ADDR_W(AW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst_n), .Gmem_R(gr), .Gmem_W(gw), .GmemAddr(ga), .dataOut(gd),
        .MEM_C(mc), .MEM_S(ms), .dataIn(din3), .ready(rdy3), .err(err3), .ram_en(en3),
        .ram_we(we3), .ram_addr(ad3), .ram_wdata(wd3), .ram_rdata(rdata3));

    // RAM models: latency 1 and latency 3
    logic [31:0] mem1 [0:(1<<AW)-1];
    logic [31:0] mem3 [0:(1<<AW)-1];
    logic [31:0] rq1, rq3, s3a, s3b;

    always @(posedge clk) begin
        if (en1) begin
            if (we1) mem1[ad1] <= wd1;
            else     rq1 <= mem1[ad1];
        end
    end
    assign rdata1 = rq1;

    always @(posedge clk) begin
        if (en3) begin
            if (we3) mem3[ad3] <= wd3;
            else     rq3 <= mem3[ad3];
        end
        s3a <= rq3;
        s3b <= s3a;
    end
    assign rdata3 = s3b;

    logic          en_v [2], we_v [2], rdy_v [2], err_v [2];
    logic [31:0]   din_v [2], wd_v [2];
    logic [AW-1:0] ad_v [2];
    assign en_v[0] = en1;   assign en_v[1] = en3;
    assign we_v[0] = we1;   assign we_v[1] = we3;
    assign rdy_v[0] = rdy1; assign rdy_v[1] = rdy3;
    assign err_v[0] = err1; assign err_v[1] = err3;
    assign din_v[0] = din1; assign din_v[1] = din3;
    assign wd_v[0] = wd1;   assign wd_v[1] = wd3;
    assign ad_v[0] = ad1;   assign ad_v[1] = ad3;

    int          n_chk = 0;
    int          n_fail = 0;
    sb_t         q1[$];
    sb_t         q3[$];
    logic [31:0] refm [0:(1<<AW)-1];
    logic [31:0] last_ld = 32'h0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_k%0d_din", tag, k), din_v[k], 32'h0);
            chk($sformatf("%s_k%0d_rdy", tag, k), 32'(rdy_v[k]), 32'h0);
            chk($sformatf("%s_k%0d_err", tag, k), 32'(err_v[k]), 32'h0);
            chk($sformatf("%s_k%0d_en", tag, k), 32'(en_v[k]), 32'h0);
            chk($sformatf("%s_k%0d_we", tag, k), 32'(we_v[k]), 32'h0);
            chk($sformatf("%s_k%0d_addr", tag, k), 32'(ad_v[k]), 32'h0);
            chk($sformatf("%s_k%0d_wdata", tag, k), wd_v[k], 32'h0);
        end
    endtask

    // Issue one request and follow both instances for a fixed window.
    task automatic op(input string tag, input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] sd, input logic [1:0] c, input logic s);
        logic [AW-1:0] wi;
        logic [31:0]   old, nw, exp_d;
        logic [7:0]    b;
        logic [15:0]   h;
        logic          word, half, mis;
        logic [15:0]   en_m [2], we_m [2], rd_m [2], xen [2], xwe [2], xrd [2];
        sb_t           e, got;
        int            lat;

        wi   = a[AW+1:2];
        old  = refm[wi];
        word = (c == 2'b00) || (c == 2'b11);
        half = (c == 2'b01);
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
        mis = (word && (a[1:0] != 2'b00)) || (half && a[0]);
`else
        mis = 1'b0;
`endif
        nw    = old;
        exp_d = last_ld;
        if (!mis && w) begin
            if (word) nw = sd;
            else if (half) nw = a[1] ? {sd[15:0], old[15:0]} : {old[31:16], sd[15:0]};
            else case (a[1:0])
                2'd0: nw = {old[31:8], sd[7:0]};
                2'd1: nw = {old[31:16], sd[7:0], old[7:0]};
                2'd2: nw = {old[31:24], sd[7:0], old[15:0]};
                default: nw = {sd[7:0], old[23:0]};
            endcase
            refm[wi] = nw;
        end else if (!mis) begin
            if (word) exp_d = old;
            else if (half) begin
                h = a[1] ? old[31:16] : old[15:0];
                exp_d = s ? {{16{h[15]}}, h} : {16'h0, h};
            end else begin
                case (a[1:0])
                    2'd0: b = old[7:0];
                    2'd1: b = old[15:8];
                    2'd2: b = old[23:16];
                    default: b = old[31:24];
                endcase
                exp_d = s ? {{24{b[7]}}, b} : {24'h0, b};
            end
            last_ld = exp_d;
        end

        for (int k = 0; k < 2; k++) begin
            int L;
            L = (k == 0) ? 1 : 3;
            en_m[k] = '0; we_m[k] = '0; rd_m[k] = '0;
            if (mis) begin
                xen[k] = '0; xwe[k] = '0; lat = 1;
            end else if (w && word) begin
                xen[k] = 16'h2; xwe[k] = 16'h2; lat = 2;
            end else if (w) begin
                xen[k] = 16'h2 | (16'h1 << (2 + L)); xwe[k] = 16'h1 << (2 + L); lat = 3 + L;
            end else begin
                xen[k] = 16'h2; xwe[k] = '0; lat = 2 + L;
            end
            xrd[k] = 16'h1 << lat;
            e.data = exp_d; e.lat = lat; e.err = mis;
            if (k == 0) q1.push_back(e); else q3.push_back(e);
        end

        @(negedge clk);
        gw = w; gr = r; ga = a; gd = sd; mc = c; ms = s;
        for (int off = 1; off < 12; off++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                en_m[k][off] = en_v[k];
                we_m[k][off] = we_v[k];
                rd_m[k][off] = rdy_v[k];
                if (en_v[k])
                    chk($sformatf("%s_k%0d_addr", tag, k), 32'(ad_v[k]), 32'(wi));
                if (we_v[k])
                    chk($sformatf("%s_k%0d_wdata", tag, k), wd_v[k], nw);
                if (rdy_v[k]) begin
                    if ((k == 0 && q1.size() == 0) || (k == 1 && q3.size() == 0)) begin
                        chk($sformatf("%s_k%0d_spurious_ready", tag, k), 32'h1, 32'h0);
                    end else begin
                        got = (k == 0) ? q1.pop_front() : q3.pop_front();
                        chk($sformatf("%s_k%0d_data", tag, k), din_v[k], got.data);
                        chk($sformatf("%s_k%0d_lat", tag, k), 32'(off), 32'(got.lat));
                        chk($sformatf("%s_k%0d_err", tag, k), 32'(err_v[k]), 32'(got.err));
                    end
                end
            end
            // Request lasts one cycle; scramble inputs afterwards to show they are ignored.
            if (off == 1) begin
                gw = 1'b0; gr = 1'b0; ga = $urandom; gd = $urandom; mc = 2'($urandom); ms = 1'($urandom);
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_k%0d_en_cycles", tag, k), 32'(en_m[k]), 32'(xen[k]));
            chk($sformatf("%s_k%0d_we_cycles", tag, k), 32'(we_m[k]), 32'(xwe[k]));
            chk($sformatf("%s_k%0d_ready_cycles", tag, k), 32'(rd_m[k]), 32'(xrd[k]));
        end
        chk({tag, "_pending"}, 32'(q1.size() + q3.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] we_seen;
        rst_n = 1'b0; gr = 1'b0; gw = 1'b0; ga = '0; gd = '0; mc = '0; ms = 1'b0;
        repeat (3) @(negedge clk);
        rst_chk("por");
        rst_n = 1'b1;
        @(negedge clk);

        op("wst10",  1, 0, 32'h10, 32'h1234_5678, 2'b00, 0);
        op("wld10",  0, 1, 32'h10, 32'h0,         2'b00, 0);
        op("bst11",  1, 0, 32'h11, 32'h0000_00AB, 2'b10, 0);
        op("wld10b", 0, 1, 32'h10, 32'h0,         2'b00, 0);
        op("wst20",  1, 0, 32'h20, 32'h8001_0000, 2'b11, 0);
        op("hld22s", 0, 1, 32'h22, 32'h0,         2'b01, 1);
        op("hld22u", 0, 1, 32'h22, 32'h0,         2'b01, 0);
        op("wst30",  1, 0, 32'h30, 32'h7F00_0000, 2'b00, 0);
        op("bld33s", 0, 1, 32'h33, 32'h0,         2'b10, 1);
        op("bld31s", 0, 1, 32'h31, 32'h0,         2'b10, 1);
        op("hst20rw",1, 1, 32'h20, 32'h5A5A_BEEF, 2'b01, 0);
        op("hld20s", 0, 1, 32'h20, 32'h0,         2'b01, 1);
        op("wst00",  1, 0, 32'h00, 32'hCAFE_F00D, 2'b00, 0);
        op("wld02",  0, 1, 32'h02, 32'h0,         2'b00, 0);
        op("hld21u", 0, 1, 32'h21, 32'h0,         2'b01, 0);
        op("bst33",  1, 0, 32'h33, 32'hFFFF_FF11, 2'b10, 0);
        op("wld30",  0, 1, 32'h30, 32'h0,         2'b00, 0);

        // Reset during the read phase of a byte store: the write must never happen.
        @(negedge clk);
        gw = 1'b1; ga = 32'h31; gd = 32'h55; mc = 2'b10;
        @(negedge clk);
        gw = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_chk("abort");
        last_ld = 32'h0;
        we_seen = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            we_seen[i] = we1 | we3;
        end
        chk("abort_no_write", 32'(we_seen), 32'h0);
        op("wld30post", 0, 1, 32'h30, 32'h0, 2'b00, 0);
        op("bld32post", 0, 1, 32'h32, 32'h0, 2'b10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
